// File: rtl/fixed_point_div_int_int.sv
// Sequential signed integer divider producing a decimal fixed-point quotient
// (fixed_X integer part, fixed_Y truncated decimal fraction digits).
module fixed_point_div_int_int #(
    parameter int unsigned FRAC_DIGITS = 5,
    parameter int unsigned INT_MAX     = 255
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic signed [20:0] numerator,
    input  logic signed [20:0] denominator,
    output logic signed [9:0]  fixed_X,
    output logic        [17:0] fixed_Y,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int unsigned OPW   = 21;
    localparam int unsigned RW    = 25;
    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 18;
    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] INT_LAST  = CNT_W'(OPW - 1);
    localparam logic [CNT_W-1:0] FRAC_LAST = CNT_W'(FRAC_DIGITS * 4 - 1);
    localparam logic [YW-1:0]    Y_SAT     = YW'(10 ** FRAC_DIGITS - 1);
    localparam logic [XW-1:0]    X_SAT     = XW'(INT_MAX);
    localparam logic [XW-1:0]    X_NEG0    = XW'(256);

    typedef enum logic [1:0] {S_IDLE, S_INT, S_FRAC, S_FINISH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OPW-1:0]     num_q, num_d;
    logic [OPW-1:0]     den_q, den_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [OPW-1:0]     qint_q, qint_d;
    logic [3:0]         digit_q, digit_d;
    logic [YW-1:0]      yacc_q, yacc_d;
    logic               sign_q, sign_d;
    logic               dbz_q, dbz_d;

    logic signed [XW-1:0] fixed_x_d;
    logic [YW-1:0]        fixed_y_d;
    logic                 busy_d, done_d, dbz_out_d, ovf_d;

    logic [OPW-1:0] num_abs_c, den_abs_c;
    logic [RW-1:0]  den_ext_c, int_trial_c, frac_base_c, frac_dsh_c;
    logic           int_fit_c, frac_fit_c;
    logic [1:0]     frac_k_c;
    logic [3:0]     frac_digit_c;

    // Operand magnitudes; two's-complement negate of -2^20 yields 2^20 unsigned.
    assign num_abs_c = numerator[20]   ? OPW'(-numerator)   : OPW'(numerator);
    assign den_abs_c = denominator[20] ? OPW'(-denominator) : OPW'(denominator);

    // One restoring step of the integer part: shift in the next dividend bit.
    assign den_ext_c   = RW'(den_q);
    assign int_trial_c = {rem_q[RW-2:0], num_q[OPW-1]};
    assign int_fit_c   = (int_trial_c >= den_ext_c);

    // One restoring step of a fraction digit: remainder is scaled by ten at
    // the first of four sub-steps, then tested against |D| << 3, 2, 1, 0.
    assign frac_base_c  = (cnt_q[1:0] == 2'd0) ? (rem_q << 3) + (rem_q << 1) : rem_q;
    assign frac_k_c     = 2'd3 - cnt_q[1:0];
    assign frac_dsh_c   = den_ext_c << frac_k_c;
    assign frac_fit_c   = (frac_base_c >= frac_dsh_c);
    assign frac_digit_c = ((cnt_q[1:0] == 2'd0) ? 4'd0 : digit_q) | (4'(frac_fit_c) << frac_k_c);

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            rem_q       <= '0;
            qint_q      <= '0;
            digit_q     <= '0;
            yacc_q      <= '0;
            sign_q      <= 1'b0;
            dbz_q       <= 1'b0;
            fixed_X     <= '0;
            fixed_Y     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            num_q       <= num_d;
            den_q       <= den_d;
            rem_q       <= rem_d;
            qint_q      <= qint_d;
            digit_q     <= digit_d;
            yacc_q      <= yacc_d;
            sign_q      <= sign_d;
            dbz_q       <= dbz_d;
            fixed_X     <= fixed_x_d;
            fixed_Y     <= fixed_y_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= dbz_out_d;
            overflow    <= ovf_d;
        end
    end

    // Next-state, datapath and result formation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        num_d     = num_q;
        den_d     = den_q;
        rem_d     = rem_q;
        qint_d    = qint_q;
        digit_d   = digit_q;
        yacc_d    = yacc_q;
        sign_d    = sign_q;
        dbz_d     = dbz_q;
        fixed_x_d = fixed_X;
        fixed_y_d = fixed_Y;
        busy_d    = busy;
        done_d    = 1'b0;
        dbz_out_d = div_by_zero;
        ovf_d     = overflow;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d   = num_abs_c;
                    den_d   = den_abs_c;
                    sign_d  = numerator[20] ^ denominator[20];
                    dbz_d   = (denominator == '0);
                    rem_d   = '0;
                    qint_d  = '0;
                    digit_d = '0;
                    yacc_d  = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                // A zero divisor leaves after one cycle, giving a two-edge latency.
                if (dbz_q) begin
                    state_d = S_FINISH;
                end else begin
                    num_d  = {num_q[OPW-2:0], 1'b0};
                    rem_d  = int_fit_c ? int_trial_c - den_ext_c : int_trial_c;
                    qint_d = {qint_q[OPW-2:0], int_fit_c};
                    if (cnt_q == INT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_FRAC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FRAC: begin
                rem_d   = frac_fit_c ? frac_base_c - frac_dsh_c : frac_base_c;
                digit_d = frac_digit_c;
                if (cnt_q[1:0] == 2'd3) begin
                    yacc_d = yacc_q * YW'(10) + YW'(frac_digit_c);
                end
                if (cnt_q == FRAC_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (dbz_q) begin
                    fixed_x_d = X_SAT;
                    fixed_y_d = Y_SAT;
                    dbz_out_d = 1'b1;
                    ovf_d     = 1'b0;
                end else if (qint_q > OPW'(INT_MAX)) begin
                    fixed_x_d = sign_q ? XW'(0) - X_SAT : X_SAT;
                    fixed_y_d = Y_SAT;
                    dbz_out_d = 1'b0;
                    ovf_d     = 1'b1;
                end else begin
                    dbz_out_d = 1'b0;
                    ovf_d     = 1'b0;
                    fixed_y_d = yacc_q;
                    // A truncated zero is always reported as positive zero.
                    if (qint_q == '0 && yacc_q == '0) begin
                        fixed_x_d = '0;
                    end else if (sign_q) begin
                        fixed_x_d = (qint_q == '0) ? X_NEG0 : XW'(0) - qint_q[XW-1:0];
                    end else begin
                        fixed_x_d = qint_q[XW-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fixed_point_div_int_int.sv
// Directed bench for fixed_point_div_int_int with an arithmetic reference model
// and a per-cycle output comparator.
module tb_fixed_point_div_int_int;

    logic               clock;
    logic               resetn;
    logic               start;
    logic signed [20:0] numerator;
    logic signed [20:0] denominator;
    logic signed [9:0]  fixed_X;
    logic [17:0]        fixed_Y;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    logic               overflow;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_x = 0, exp_y = 0;
    bit exp_dbz = 0, exp_ovf = 0, exp_busy = 0, exp_done = 0;

    fixed_point_div_int_int #(.FRAC_DIGITS(5), .INT_MAX(255)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .numerator   (numerator),
        .denominator (denominator),
        .fixed_X     (fixed_X),
        .fixed_Y     (fixed_Y),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    endtask

    // Reference: plain integer division of magnitudes, decimal truncation.
    function automatic void model(input int n, input int d, output int x, output int y,
                                  output bit dbz, output bit ovf);
        longint an, ad, qi, r;
        bit neg;
        x = 0; y = 0; dbz = 0; ovf = 0;
        if (d == 0) begin
            x = 255; y = 99999; dbz = 1;
            return;
        end
        an  = (n < 0) ? -longint'(n) : longint'(n);
        ad  = (d < 0) ? -longint'(d) : longint'(d);
        neg = (n < 0) != (d < 0);
        qi  = an / ad;
        r   = an % ad;
        if (qi > 255) begin
            x = neg ? -255 : 255; y = 99999; ovf = 1;
            return;
        end
        y = int'((r * 100000) / ad);
        if (qi == 0 && y == 0) x = 0;
        else if (neg) x = (qi == 0) ? 256 : -int'(qi);
        else x = int'(qi);
    endfunction

    // Outputs must match the expected registered state on every cycle.
    always @(negedge clock) begin
        chk("fixed_X", int'(fixed_X), exp_x);
        chk("fixed_Y", int'(fixed_Y), exp_y);
        chk("div_by_zero", int'(div_by_zero), int'(exp_dbz));
        chk("overflow", int'(overflow), int'(exp_ovf));
        chk("busy", int'(busy), int'(exp_busy));
        chk("done", int'(done), int'(exp_done));
    end

    task automatic pin_model(input int n, input int d, input int x, input int y);
        int mx, my;
        bit mdbz, movf;
        model(n, d, mx, my, mdbz, movf);
        chk($sformatf("model %0d/%0d X", n, d), mx, x);
        chk($sformatf("model %0d/%0d Y", n, d), my, y);
    endtask

    // Run one division; poke>0 raises a stray start sampled at edge E+poke.
    task automatic do_div(input int n, input int d, input int poke);
        int ex, ey, lat;
        bit edbz, eovf;
        model(n, d, ex, ey, edbz, eovf);
        lat = (d == 0) ? 2 : 42;
        @(negedge clock);
        numerator   = 21'(n);
        denominator = 21'(d);
        start       = 1'b1;
        @(posedge clock); #1;
        start     = 1'b0;
        exp_busy  = 1'b1;
        exp_done  = 1'b0;
        numerator = 21'(n + 7);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clock); #1;
            if (poke != 0 && i == poke - 1) begin
                start       = 1'b1;
                numerator   = 21'sd99;
                denominator = 21'sd1;
            end
            if (poke != 0 && i == poke) start = 1'b0;
            if (i == lat) begin
                exp_busy = 1'b0;
                exp_done = 1'b1;
                exp_x    = ex;
                exp_y    = ey;
                exp_dbz  = edbz;
                exp_ovf  = eovf;
            end
        end
    endtask

    task automatic lit(input string name, input int x, input int y, input int dbz, input int ovf);
        chk({name, " X"}, int'(fixed_X), x);
        chk({name, " Y"}, int'(fixed_Y), y);
        chk({name, " dbz"}, int'(div_by_zero), dbz);
        chk({name, " ovf"}, int'(overflow), ovf);
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clock); #1;
            exp_done = 1'b0;
        end
    endtask

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        numerator   = '0;
        denominator = '0;
        repeat (3) @(negedge clock);
        @(posedge clock); #2;
        resetn = 1'b1;

        pin_model(7, 2, 3, 50000);
        pin_model(-1, 3, 256, 33333);
        pin_model(-1, 200000, 0, 0);
        pin_model(-1000, 3, -255, 99999);
        pin_model(5, 0, 255, 99999);

        do_div(7, 2, 0);              lit("7/2", 3, 50000, 0, 0);
        do_div(-7, 2, 0);             lit("-7/2", -3, 50000, 0, 0);
        do_div(7, -2, 0);             lit("7/-2", -3, 50000, 0, 0);
        do_div(-1, 3, 0);             lit("-1/3", 256, 33333, 0, 0);
        do_div(-1, 200000, 0);        lit("-1/200000", 0, 0, 0, 0);
        do_div(1000, 3, 0);           lit("1000/3", 255, 99999, 0, 1);
        do_div(-1000, 3, 0);          lit("-1000/3", -255, 99999, 0, 1);
        do_div(5, 0, 0);              lit("5/0", 255, 99999, 1, 0);
        do_div(1, 4, 0);              lit("1/4", 0, 25000, 0, 0);
        do_div(-1048576, -1048576, 0); lit("min/min", 1, 0, 0, 0);
        do_div(1, 1048575, 0);        lit("1/max", 0, 0, 0, 0);
        do_div(255, 1, 0);            lit("255/1", 255, 0, 0, 0);
        do_div(256, 1, 0);            lit("256/1", 255, 99999, 0, 1);
        do_div(-1048576, 1, 0);       lit("min/1", -255, 99999, 0, 1);
        do_div(0, -5, 0);             lit("0/-5", 0, 0, 0, 0);
        do_div(22, -7, 0);            lit("22/-7", -3, 14285, 0, 0);
        idle(5);
        do_div(20, 3, 10);            lit("20/3 poked", 6, 66666, 0, 0);
        idle(60);

        // Reset during a division abandons it.
        @(negedge clock);
        numerator   = 21'sd300;
        denominator = 21'sd7;
        start       = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        exp_busy = 1'b1;
        exp_done = 1'b0;
        repeat (19) @(posedge clock);
        @(posedge clock); #2;
        resetn   = 1'b0;
        exp_x    = 0;
        exp_y    = 0;
        exp_dbz  = 1'b0;
        exp_ovf  = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        resetn = 1'b1;
        idle(50);

        do_div(-1, 4, 0);             lit("-1/4", 256, 25000, 0, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
